// File: rtl/systolic_result_reader.sv
// -----------------------------------------------------------------------------
// systolic_result_reader
//
// Controller and result reader for the 3x3 systolic multiplier. One START
// pulse clears the array for one cycle, enables it, waits for MULTI_OVER and
// then captures all nine results in a single cycle. The captured matrix is
// streamed out row-major over a valid/ready handshake. Timeouts and START
// requests that arrive while busy are reported through sticky flags.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   start                    single-cycle request to run one multiply
//   clr_err                  clears timeout_err and start_drop
//   c_in_1x1 .. c_in_3x3     result elements C(i,j) from the array
//   multi_over               array done/valid flag
//   array_en                 drives the array ENABLE input
//   array_clr_n              drives the array RST input (active-low clear)
//   out_data/out_idx         current element and its row-major index 0..8
//   out_valid/out_ready      output handshake
//   out_last                 marks element 8
//   busy                     high in any state except IDLE
//   done                     one-cycle pulse after element 8 is accepted
//   timeout_err, start_drop  sticky error flags
// -----------------------------------------------------------------------------
module systolic_result_reader #(
   parameter int WIDTH_SUM = 8,
   parameter int TIMEOUT   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clr_err,
   input  logic [WIDTH_SUM-1:0] c_in_1x1,
   input  logic [WIDTH_SUM-1:0] c_in_1x2,
   input  logic [WIDTH_SUM-1:0] c_in_1x3,
   input  logic [WIDTH_SUM-1:0] c_in_2x1,
   input  logic [WIDTH_SUM-1:0] c_in_2x2,
   input  logic [WIDTH_SUM-1:0] c_in_2x3,
   input  logic [WIDTH_SUM-1:0] c_in_3x1,
   input  logic [WIDTH_SUM-1:0] c_in_3x2,
   input  logic [WIDTH_SUM-1:0] c_in_3x3,
   input  logic                 multi_over,
   output logic                 array_en,
   output logic                 array_clr_n,
   output logic [WIDTH_SUM-1:0] out_data,
   output logic [3:0]           out_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   output logic                 start_drop
);

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

   localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);
   localparam logic [3:0] LAST_IDX  = 4'd8;

   state_t               state_q, state_d;
   logic [7:0]           timer_q, timer_d;
   logic [WIDTH_SUM-1:0] buf_q [9];
   logic [WIDTH_SUM-1:0] buf_d [9];
   logic [WIDTH_SUM-1:0] c_in  [9];
   logic [3:0]           next_idx;

   logic                 array_en_d, array_clr_n_d, out_valid_d, out_last_d;
   logic                 busy_d, done_d, timeout_err_d, start_drop_d;
   logic [WIDTH_SUM-1:0] out_data_d;
   logic [3:0]           out_idx_d;

   assign c_in[0]  = c_in_1x1;
   assign c_in[1]  = c_in_1x2;
   assign c_in[2]  = c_in_1x3;
   assign c_in[3]  = c_in_2x1;
   assign c_in[4]  = c_in_2x2;
   assign c_in[5]  = c_in_2x3;
   assign c_in[6]  = c_in_3x1;
   assign c_in[7]  = c_in_3x2;
   assign c_in[8]  = c_in_3x3;

   assign next_idx = out_idx + 4'd1;

   // Next-state and next-output logic. Every output is registered, so this
   // block computes the value each output takes after the coming edge.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d       = state_q;
      timer_d       = timer_q;
      buf_d         = buf_q;
      array_en_d    = array_en;
      array_clr_n_d = array_clr_n;
      out_data_d    = out_data;
      out_idx_d     = out_idx;
      out_valid_d   = out_valid;
      out_last_d    = out_last;
      busy_d        = busy;
      done_d        = 1'b0;

      // Clear first so a set condition on the same edge overrides it.
      timeout_err_d = timeout_err & ~clr_err;
      start_drop_d  = start_drop  & ~clr_err;

      // START is only honoured in IDLE; anywhere else it is a drop, including
      // the edge on which DRAIN hands back to IDLE.
      if (start && state_q != ST_IDLE) begin
         start_drop_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_CLEAR;
               busy_d        = 1'b1;
               array_clr_n_d = 1'b0;
               array_en_d    = 1'b0;
            end
         end

         ST_CLEAR: begin
            state_d       = ST_RUN;
            array_clr_n_d = 1'b1;
            array_en_d    = 1'b1;
            timer_d       = '0;
         end

         ST_RUN: begin
            // Capture takes priority over the timeout on the same edge.
            if (multi_over) begin
               buf_d       = c_in;
               state_d     = ST_DRAIN;
               array_en_d  = 1'b0;
               out_valid_d = 1'b1;
               out_idx_d   = '0;
               out_data_d  = c_in[0];
               out_last_d  = 1'b0;
            end else if (timer_q == TIMER_MAX) begin
               state_d       = ST_IDLE;
               array_en_d    = 1'b0;
               busy_d        = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end

         ST_DRAIN: begin
            // out_valid is always high here, so acceptance is just out_ready.
            if (out_ready) begin
               if (out_idx == LAST_IDX) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_idx_d   = '0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  out_idx_d  = next_idx;
                  out_data_d = buf_q[next_idx];
                  out_last_d = (next_idx == LAST_IDX);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         array_en    <= 1'b0;
         array_clr_n <= 1'b1;
         out_data    <= '0;
         out_idx     <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         start_drop  <= 1'b0;
         // NOTE: the capture buffer is reset explicitly; it is nine small registers, not a RAM macro.
         for (int i = 0; i < 9; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         array_en    <= array_en_d;
         array_clr_n <= array_clr_n_d;
         out_data    <= out_data_d;
         out_idx     <= out_idx_d;
         out_valid   <= out_valid_d;
         out_last    <= out_last_d;
         busy        <= busy_d;
         done        <= done_d;
         timeout_err <= timeout_err_d;
         start_drop  <= start_drop_d;
         buf_q       <= buf_d;
      end
   end

endmodule

// File: tb/tb_systolic_result_reader.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_reader
//
// Directed and randomized bench for systolic_result_reader. The drained
// stream is checked against a queue holding the captured matrix: each cycle
// the head of the queue must be on the output, and it is popped only when the
// bench itself drove out_ready. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_systolic_result_reader;

   localparam int W  = 8;
   localparam int TO = 32;

   typedef logic [8:0][W-1:0] mat_t;

   logic         clk = 1'b0;
   logic         rst_n, start, clr_err, multi_over, out_ready;
   logic [W-1:0] c_in [9];
   logic         array_en, array_clr_n, out_valid, out_last;
   logic         busy, done, timeout_err, start_drop;
   logic [W-1:0] out_data;
   logic [3:0]   out_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   systolic_result_reader #(.WIDTH_SUM(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clr_err(clr_err),
      .c_in_1x1(c_in[0]), .c_in_1x2(c_in[1]), .c_in_1x3(c_in[2]),
      .c_in_2x1(c_in[3]), .c_in_2x2(c_in[4]), .c_in_2x3(c_in[5]),
      .c_in_3x1(c_in[6]), .c_in_3x2(c_in[7]), .c_in_3x3(c_in[8]),
      .multi_over(multi_over), .array_en(array_en), .array_clr_n(array_clr_n),
      .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
      .timeout_err(timeout_err), .start_drop(start_drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // START pulse, one CLEAR cycle, then `delay` RUN cycles without MULTI_OVER.
   task automatic start_run(input int delay, input bit drop_in_run);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clear_busy", busy, 1);
      check("clear_clr_n", array_clr_n, 0);
      check("clear_en", array_en, 0);
      tick();
      check("run_en", array_en, 1);
      check("run_clr_n", array_clr_n, 1);
      for (int i = 0; i < delay; i++) begin
         if (drop_in_run && i == 0) start = 1'b1;
         tick();
         start = 1'b0;
         check("run_wait_en", array_en, 1);
         check("run_wait_valid", out_valid, 0);
      end
   endtask

   // Present the matrix with MULTI_OVER for one edge, then scramble the inputs.
   task automatic capture(input mat_t m, input bit isolate);
      for (int i = 0; i < 9; i++) c_in[i] = m[i];
      multi_over = 1'b1;
      tick();
      multi_over = 1'b0;
      for (int i = 0; i < 9; i++) c_in[i] = isolate ? 8'hFF : 8'($urandom);
      check("cap_valid", out_valid, 1);
      check("cap_en", array_en, 0);
   endtask

   // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
   // start_at: drain cycle on which START is also pulsed (-1 for none).
   task automatic drain(input mat_t m, input int mode, input int start_at);
      logic [W-1:0] q[$];
      int           cyc;
      bit           rdy;
      cyc = 0;
      for (int i = 0; i < 9; i++) q.push_back(m[i]);
      while (q.size() != 0 && cyc < 200) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         check("drain_valid", out_valid, 1);
         check("drain_idx", out_idx, 9 - q.size());
         check("drain_data", out_data, q[0]);
         check("drain_last", out_last, q.size() == 1);
         check("drain_done", done, 0);
         check("drain_busy", busy, 1);
         if (cyc == start_at) start = 1'b1;
         tick();
         start = 1'b0;
         if (rdy) void'(q.pop_front());
         cyc++;
      end
      out_ready = 1'b0;
      check("drain_left", q.size(), 0);
      check("end_done", done, 1);
      check("end_valid", out_valid, 0);
      check("end_last", out_last, 0);
      check("end_busy", busy, 0);
      check("end_idx", out_idx, 0);
      tick();
      check("end_done_pulse", done, 0);
   endtask

   task automatic pulse_clr_err();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_en"}, array_en, 0);
      check({tag, "_clr_n"}, array_clr_n, 1);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_idx"}, out_idx, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_terr"}, timeout_err, 0);
      check({tag, "_drop"}, start_drop, 0);
   endtask

   initial begin
      mat_t basic, rm;
      int   bv[9];
      int   n;

      bv = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
      for (int i = 0; i < 9; i++) basic[i] = W'(bv[i]);

      rst_n = 1'b1; start = 1'b0; clr_err = 1'b0; multi_over = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 9; i++) c_in[i] = '0;
      #1 rst_n = 1'b0;
      #2 check_reset_values("reset");
      #4 rst_n = 1'b1;
      tick();

      // MULTI_OVER in IDLE is ignored.
      multi_over = 1'b1;
      tick();
      multi_over = 1'b0;
      check("idle_mo_busy", busy, 0);
      check("idle_mo_valid", out_valid, 0);

      // Basic matrix, continuous ready.
      start_run(0, 1'b0);
      capture(basic, 1'b0);
      drain(basic, 0, -1);

      // Backpressure with ready pattern 1,0,0,1.
      start_run(2, 1'b0);
      capture(basic, 1'b0);
      drain(basic, 1, -1);

      // Capture isolation: array outputs go to 0xFF right after capture.
      start_run(1, 1'b0);
      capture(basic, 1'b1);
      drain(basic, 0, -1);

      // Timeout: MULTI_OVER never asserted.
      start_run(0, 1'b0);
      n = 0;
      while (array_en && n < 100) begin
         tick();
         n++;
         check("to_valid", out_valid, 0);
      end
      check("to_cycles", n, TO);
      check("to_err", timeout_err, 1);
      check("to_busy", busy, 0);
      check("to_done", done, 0);
      pulse_clr_err();
      check("to_cleared", timeout_err, 0);

      // MULTI_OVER on the timeout edge: capture wins, no error.
      start_run(TO - 1, 1'b0);
      capture(basic, 1'b0);
      check("to_edge_err", timeout_err, 0);
      drain(basic, 0, -1);

      // CLR_ERR on the timeout edge: the set wins.
      start_run(TO - 1, 1'b0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("to_setwins_err", timeout_err, 1);
      check("to_setwins_busy", busy, 0);
      pulse_clr_err();
      check("to_setwins_clear", timeout_err, 0);

      // Dropped start in RUN and in DRAIN: one stream, no second CLEAR.
      start_run(2, 1'b1);
      check("drop_run", start_drop, 1);
      capture(basic, 1'b0);
      drain(basic, 0, 3);
      check("drop_drain", start_drop, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drop_no_clear", array_clr_n, 1);
         check("drop_idle", busy, 0);
      end
      pulse_clr_err();
      check("drop_cleared", start_drop, 0);

      // START on the edge DRAIN returns to IDLE is also a drop.
      start_run(0, 1'b0);
      capture(basic, 1'b0);
      drain(basic, 0, 8);
      check("drop_last", start_drop, 1);
      check("drop_last_no_clear", array_clr_n, 1);
      tick();
      check("drop_last_idle", busy, 0);

      // Async reset during DRAIN at OUT_IDX=4 (start_drop still set going in).
      start_run(0, 1'b0);
      capture(basic, 1'b0);
      out_ready = 1'b1;
      n = 0;
      while (out_idx != 4'd4 && n < 20) begin
         tick();
         n++;
      end
      check("rst_mid_idx", out_idx, 4);
      check("rst_mid_data", out_data, 81);
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      #2 rst_n = 1'b1;
      out_ready = 1'b0;
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      start_run(1, 1'b0);
      capture(basic, 1'b0);
      drain(basic, 0, -1);

      // Randomized matrices, start delays and ready patterns.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 9; i++) rm[i] = W'($urandom);
         start_run(int'($urandom_range(0, 10)), 1'b0);
         capture(rm, 1'b0);
         drain(rm, 2, -1);
      end
      check("final_terr", timeout_err, 0);
      check("final_drop", start_drop, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_result_reader.md
Name: systolic_result_reader

Overview:
- Controller and result reader for the 3x3 systolic multiplier.
- Sequences one multiply: clears the array, enables it, waits for the array's done flag, then captures all nine 8-bit results in one cycle.
- Streams the captured results out row-major over a valid/ready handshake to the downstream consumer (bus bridge or result FIFO).
- Reports timeouts and dropped start requests through sticky flags.

Parameters:
- WIDTH_SUM, 8, width of each result element C(i,j) and of OUT_DATA.
- TIMEOUT, 32, max RUN cycles waiting for MULTI_OVER before abort; legal range 2..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  single-cycle request to run one multiply.
- CLR_ERR  in  1  clears the sticky flags.
- C_IN_1x1 .. C_IN_3x3  in  WIDTH_SUM each (9 ports)  result elements from the array.
- MULTI_OVER  in  1  array done/valid flag.
- ARRAY_EN  out  1  drives the array ENABLE input.
- ARRAY_CLR_N  out  1  drives the array RST input; active-low clear.
- OUT_DATA  out  WIDTH_SUM  current result element.
- OUT_IDX  out  4  element index 0..8 (row*3+col, row-major).
- OUT_VALID  out  1  OUT_DATA/OUT_IDX valid.
- OUT_READY  in  1  consumer accepts the element.
- OUT_LAST  out  1  high with OUT_VALID when OUT_IDX==8.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse after element 8 is accepted.
- TIMEOUT_ERR  out  1  sticky: RUN aborted by timeout.
- START_DROP  out  1  sticky: START arrived while BUSY.

Behaviour:
- All outputs are registered.
- Reset values (RST low, applied immediately): state=IDLE, ARRAY_EN=0, ARRAY_CLR_N=1, OUT_VALID=0, OUT_DATA=0, OUT_IDX=0, OUT_LAST=0, BUSY=0, DONE=0, both sticky flags 0, capture buffer all 0, timer 0.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - START=1 at edge k → CLEAR. After edge k: BUSY=1, ARRAY_CLR_N=0.
  - MULTI_OVER is ignored.
- CLEAR (exactly 1 cycle): ARRAY_CLR_N=0, ARRAY_EN=0.
  - Next edge → RUN: ARRAY_CLR_N=1, ARRAY_EN=1, timer=0.
- RUN: ARRAY_EN=1. Timer increments every cycle.
  - MULTI_OVER=1 at an edge: all nine C_IN values sampled into the buffer at that same edge → DRAIN. After that edge: ARRAY_EN=0, OUT_VALID=1, OUT_IDX=0, OUT_DATA=C(1,1).
  - Timer reaching TIMEOUT-1 with MULTI_OVER=0 → IDLE. TIMEOUT_ERR set, ARRAY_EN=0, no DONE, buffer unchanged.
  - If MULTI_OVER=1 on the timeout edge, capture wins and no error is raised.
- DRAIN:
  - OUT_VALID stays high. OUT_DATA and OUT_IDX are held stable while OUT_READY=0.
  - Each edge with OUT_VALID&OUT_READY advances OUT_IDX by 1 and presents the next buffer element, one element per cycle maximum.
  - Acceptance at OUT_IDX==8 → IDLE. After that edge: OUT_VALID=0, OUT_LAST=0, BUSY=0, OUT_IDX=0, DONE=1 for exactly one cycle.
  - MULTI_OVER is ignored. The buffer is frozen; array output changes do not affect the drained data.
- Minimum latency START→first OUT_VALID: 2 cycles plus array latency. With continuous OUT_READY the drain takes 9 cycles.
- START while BUSY=1 is ignored and sets START_DROP.
- START on the same edge that DRAIN returns to IDLE is also a drop; START is sampled in IDLE only.
- Sticky flags are cleared by CLR_ERR=1 at an edge. If CLR_ERR and a new set condition occur on the same edge, the set wins.
- Reset asserted mid-operation: return to reset values asynchronously. No partial DONE. ARRAY_CLR_N returns to 1 and ARRAY_EN to 0.
- No arithmetic is performed; data passes through unmodified at WIDTH_SUM bits.
- OUT_IDX wraps only via the return to IDLE and never exceeds 8.

Test Plan:
- Basic matrix, model array asserts MULTI_OVER with C=[30 36 42; 66 81 96; 102 126 150] (A=B=[1 2 3;4 5 6;7 8 9]), OUT_READY=1 → ARRAY_CLR_N low for 1 cycle, then stream 30,36,42,66,81,96,102,126,150 on consecutive cycles with OUT_IDX 0..8, OUT_LAST with 150, DONE one cycle later.
- Backpressure: OUT_READY toggled 1,0,0,1 repeating → every element appears exactly once, in order, stable while stalled; DONE only after 150 is accepted.
- Capture isolation: model changes all C_IN to 0xFF one cycle after MULTI_OVER → drained values remain 30..150 unchanged.
- Timeout: MULTI_OVER never asserted, TIMEOUT=32 → ARRAY_EN drops after 32 RUN cycles, TIMEOUT_ERR=1, BUSY=0, OUT_VALID never asserted. CLR_ERR pulse then clears TIMEOUT_ERR.
- Dropped start: START pulsed in RUN and again in DRAIN → START_DROP=1, only one 9-element stream, no second CLEAR.
- Async reset during DRAIN at OUT_IDX=4 → outputs return to reset values immediately without a clock edge; a following START runs a clean, complete 9-element sequence.
